// File: rtl/distance_decoder_pkg.sv
// Shared definitions for the distance decoder: default widths, the address
// width relation and the controller state encoding.
package distance_decoder_pkg;

  localparam int WORD_WIDTH_DEF = 8;
  localparam int DIST_WIDTH_DEF = 7;

  // Linear input-plane addresses need room for a full row index times a row width.
  function automatic int addr_width(input int word_width);
    return 2 * word_width;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV_K = 3'd1,
    MAP   = 3'd2,
    DIV_O = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/iter_divider.sv
// Restoring radix-2 divider, one quotient bit per clock. A start pulse loads
// the operands; 'steps' selects how many low-order dividend bits take part.
module iter_divider #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CW-1:0]    steps,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    steps_r;
  logic             busy_r;

  logic [WIDTH:0]   shift_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_s;
  logic             done_s;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  always_comb begin
    shift_s = {rem_r, quo_r[WIDTH-1]};
    ge_s    = (shift_s >= {1'b0, div_r});
    if (ge_s) begin
      rem_s = WIDTH'(shift_s - {1'b0, div_r});
    end else begin
      rem_s = shift_s[WIDTH-1:0];
    end
  end

  assign done_s = busy_r && (cnt_r == (steps_r - CW'(1)));

  // Operand load on start, then iterate until the requested step count is spent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_r   <= '0;
      div_r   <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
      steps_r <= '0;
      busy_r  <= 1'b0;
    end else if (start) begin
      // Left-align the dividend so a short division consumes only its own bits.
      quo_r   <= dividend << (CW'(WIDTH) - steps);
      div_r   <= divisor;
      rem_r   <= '0;
      cnt_r   <= '0;
      steps_r <= steps;
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      quo_r   <= {quo_r[WIDTH-2:0], ge_s};
      rem_r   <= rem_s;
      cnt_r   <= cnt_r + CW'(1);
      busy_r  <= !done_s;
    end else begin
      busy_r  <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_s;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/distance_decoder.sv
// Reconstructs the partner kernel index from a base index and a stored
// redundancy distance, using one time-shared iterative divider.
module distance_decoder
  import distance_decoder_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DIST_WIDTH = DIST_WIDTH_DEF,
  parameter int ADDR_WIDTH = addr_width(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] idx1,
  input  logic [DIST_WIDTH-1:0] dr,
  input  logic [WORD_WIDTH-1:0] ow,
  input  logic [WORD_WIDTH-1:0] fw,
  input  logic [WORD_WIDTH-1:0] st,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_idx2,
  output logic                  out_hit,
  output logic                  out_err
);

  localparam int SW = $clog2(ADDR_WIDTH + 1);
  localparam int LW = ADDR_WIDTH + WORD_WIDTH + 1;

  state_t                state_r;
  state_t                state_s;
  logic [WORD_WIDTH-1:0] ow_r;
  logic [WORD_WIDTH-1:0] fw_r;
  logic [WORD_WIDTH-1:0] st_r;
  logic [DIST_WIDTH-1:0] dr_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [WORD_WIDTH-1:0] out_idx2_r;
  logic                  out_hit_r;
  logic                  out_err_r;

  logic                  accept_s;
  logic                  illegal_s;
  logic                  div_start_s;
  logic [SW-1:0]         div_steps_s;
  logic [ADDR_WIDTH-1:0] div_dividend_s;
  logic [ADDR_WIDTH-1:0] div_divisor_s;
  logic                  div_busy_s;
  logic                  div_done_s;
  logic [ADDR_WIDTH-1:0] div_quo_s;
  logic [ADDR_WIDTH-1:0] div_rem_s;
  logic [ADDR_WIDTH-1:0] a1_s;
  logic [ADDR_WIDTH-1:0] d_s;
  logic [ADDR_WIDTH-1:0] a2_s;
  logic [LW-1:0]         lin_s;
  logic                  hit_s;

  assign accept_s  = in_valid && in_ready_r;
  assign illegal_s = (fw == '0) || (ow == '0) || (st == '0) || (ow < fw);

  // In MAP the divider holds r1/c1; in CHK it holds r2/c2.
  assign a1_s  = ADDR_WIDTH'(div_quo_s[WORD_WIDTH-1:0]) * ADDR_WIDTH'(ow_r)
               + ADDR_WIDTH'(div_rem_s[WORD_WIDTH-1:0]);
  assign d_s   = ADDR_WIDTH'(dr_r) * ADDR_WIDTH'(st_r);
  assign a2_s  = a1_s + d_s;
  assign lin_s = LW'(div_quo_s) * LW'(fw_r) + LW'(div_rem_s);
  assign hit_s = (div_rem_s < ADDR_WIDTH'(fw_r)) && (div_quo_s < ADDR_WIDTH'(fw_r))
              && (lin_s < (LW'(1) << WORD_WIDTH));

  iter_divider #(
    .WIDTH (ADDR_WIDTH),
    .CW    (SW)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start_s),
    .steps     (div_steps_s),
    .dividend  (div_dividend_s),
    .divisor   (div_divisor_s),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Next-state logic and divider sequencing.
  always_comb begin
    state_s        = state_r;
    div_start_s    = 1'b0;
    div_steps_s    = '0;
    div_dividend_s = '0;
    div_divisor_s  = '0;
    case (state_r)
      IDLE: begin
        if (accept_s && illegal_s) begin
          state_s = DONE;
        end else if (accept_s) begin
          state_s        = DIV_K;
          div_start_s    = 1'b1;
          div_steps_s    = SW'(WORD_WIDTH);
          div_dividend_s = ADDR_WIDTH'(idx1);
          div_divisor_s  = ADDR_WIDTH'(fw);
        end else begin
          state_s = IDLE;
        end
      end
      DIV_K: begin
        if (div_done_s) begin
          state_s = MAP;
        end else if (!div_busy_s) begin
          state_s = IDLE;
        end else begin
          state_s = DIV_K;
        end
      end
      MAP: begin
        state_s        = DIV_O;
        div_start_s    = 1'b1;
        div_steps_s    = SW'(ADDR_WIDTH);
        div_dividend_s = a2_s;
        div_divisor_s  = ADDR_WIDTH'(ow_r);
      end
      DIV_O: begin
        if (div_done_s) begin
          state_s = CHK;
        end else if (!div_busy_s) begin
          state_s = IDLE;
        end else begin
          state_s = DIV_O;
        end
      end
      CHK: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand capture and registered result/handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ow_r        <= '0;
      fw_r        <= '0;
      st_r        <= '0;
      dr_r        <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_idx2_r  <= '0;
      out_hit_r   <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      if (state_r == IDLE && accept_s) begin
        ow_r <= ow;
        fw_r <= fw;
        st_r <= st;
        dr_r <= dr;
      end else begin
        ow_r <= ow_r;
      end
      if (state_r == IDLE && accept_s && illegal_s) begin
        out_err_r  <= 1'b1;
        out_hit_r  <= 1'b0;
        out_idx2_r <= '0;
      end else if (state_r == CHK) begin
        out_err_r  <= 1'b0;
        out_hit_r  <= hit_s;
        out_idx2_r <= hit_s ? lin_s[WORD_WIDTH-1:0] : '0;
      end else begin
        out_err_r  <= out_err_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_idx2  = out_idx2_r;
  assign out_hit   = out_hit_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_distance_decoder.sv
// Randomised and directed bench for distance_decoder against an arithmetic
// reference model of the index reconstruction.
module tb_distance_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] idx1;
  logic [6:0] dr;
  logic [7:0] ow;
  logic [7:0] fw;
  logic [7:0] st;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_idx2;
  logic       out_hit;
  logic       out_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  distance_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idx1      (idx1),
    .dr        (dr),
    .ow        (ow),
    .fw        (fw),
    .st        (st),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx2  (out_idx2),
    .out_hit   (out_hit),
    .out_err   (out_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: straight from the index/address arithmetic, 16-bit address space.
  function automatic void model(input int i1, input int d, input int o, input int f, input int s,
                                output bit e, output bit h, output int x);
    int a1, a2, r2, c2;
    e = (f == 0) || (o == 0) || (s == 0) || (o < f);
    h = 1'b0;
    x = 0;
    if (!e) begin
      a1 = (i1 / f) * o + (i1 % f);
      a2 = (a1 + d * s) % 65536;
      r2 = a2 / o;
      c2 = a2 % o;
      h  = (c2 < f) && (r2 < f) && (r2 * f + c2 < 256);
      x  = h ? r2 * f + c2 : 0;
    end
  endfunction

  task automatic run_req(input int i1, input int d, input int o, input int f, input int s,
                         input int hold);
    bit e, h;
    int x, lat;
    model(i1, d, o, f, s, e, h, x);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    idx1 = 8'(i1); dr = 7'(d); ow = 8'(o); fw = 8'(f); st = 8'(s);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    idx1 = 8'($urandom); dr = 7'($urandom); ow = 8'($urandom); fw = 8'($urandom); st = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), e ? 32'd0 : 32'd26);
    check_eq("err", 32'(out_err), 32'(e));
    check_eq("hit", 32'(out_hit), 32'(h));
    check_eq("idx2", 32'(out_idx2), 32'(x));
    in_valid = 1'b1;
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_ready", 32'(in_ready), 32'd0);
      check_eq("hold_idx2", 32'(out_idx2), 32'(x));
      check_eq("hold_hit", 32'(out_hit), 32'(h));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("release_valid", 32'(out_valid), 32'd0);
    check_eq("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, t0, t1, f, o, s, i1, d, r2, c2, a1, a2;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    idx1 = '0; dr = '0; ow = '0; fw = '0; st = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_idx2", 32'(out_idx2), 32'd0);
    check_eq("rst_hit", 32'(out_hit), 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    reset_n = 1'b1;

    // Directed cases
    run_req(0, 21, 20, 3, 1, 0);
    run_req(0, 43, 42, 5, 2, 1);
    run_req(0, 0, 20, 5, 5, 0);
    run_req(0, 5, 20, 3, 1, 0);
    run_req(8, 20, 20, 3, 1, 0);
    run_req(4, 9, 20, 0, 1, 0);
    run_req(2, 9, 4, 5, 1, 2);
    run_req(2, 9, 20, 3, 0, 0);
    run_req(7, 11, 20, 3, 1, 10);

    // Continuous out_ready/in_valid: one result every 28 cycles
    @(negedge clk);
    idx1 = 8'd0; dr = 7'd21; ow = 8'd20; fw = 8'd3; st = 8'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    t0 = cyc;
    check_eq("tput_idx2_a", 32'(out_idx2), 32'd4);
    @(negedge clk);
    check_eq("tput_pulse", 32'(out_valid), 32'd0);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    t1 = cyc;
    check_eq("tput_interval", 32'(t1 - t0), 32'd28);
    check_eq("tput_idx2_b", 32'(out_idx2), 32'd4);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Abort in the 10th DIV_O cycle; outputs still hold idx2=4 beforehand
    @(negedge clk);
    idx1 = 8'd3; dr = 7'd40; ow = 8'd30; fw = 8'd4; st = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_idx2", 32'(out_idx2), 32'd0);
    check_eq("abort_hit", 32'(out_hit), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_req(0, 43, 42, 5, 2, 0);

    // Random operands; half the legal ones are steered to a genuine partner
    for (int n = 0; n < 30; n++) begin
      f  = $urandom_range(1, 8);
      o  = $urandom_range(f, 40);
      s  = $urandom_range(1, 8);
      i1 = $urandom_range(0, f * f - 1);
      d  = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1) begin
        r2 = $urandom_range(0, f - 1);
        c2 = $urandom_range(0, f - 1);
        a1 = (i1 / f) * o + (i1 % f);
        a2 = r2 * o + c2;
        if (a2 >= a1 && (a2 - a1) % s == 0 && (a2 - a1) / s < 128) d = (a2 - a1) / s;
      end
      case ($urandom_range(0, 7))
        0: f = 0;
        1: s = 0;
        2: o = f - 1;
        default: o = o;
      endcase
      run_req(i1, d, o, f, s, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
